// File: rtl/p_wt_update.sv
`default_nettype none
// ============================================================================
//  Module      : p_wt_update
//  Description : Perceptron weight-update stage. Takes the error produced by
//                p_sub together with the input vector behind that prediction
//                and applies w[i] += (err * x[i]) >>> LR_SHIFT one weight per
//                cycle, saturating each weight to its signed range. Holds the
//                weight register file.
//  Ports       : clk        - clock, rising edge
//                reset_     - asynchronous reset, active-low
//                init_valid - load init_w into every weight (IDLE only)
//                init_w     - initial weights, w[0] in the LSBs
//                err_valid  - err / x_vec valid
//                err_ready  - stage can accept err / x_vec
//                err        - signed error from p_sub
//                x_vec      - signed inputs, x[0] in the LSBs
//                busy       - update in progress (state != IDLE)
//                done       - one-cycle pulse when an update completes
//                sat        - at least one weight clamped in the last update
//                w_vec      - current weights, w[0] in the LSBs
//  Revision    : 1.0 - initial release
// ============================================================================
module p_wt_update #(
    parameter int N        = 4,
    parameter int W_PREC   = 8,
    parameter int X_PREC   = 8,
    parameter int E_PREC   = 9,
    parameter int LR_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  init_valid,
    input  logic [N*W_PREC-1:0]   init_w,
    input  logic                  err_valid,
    output logic                  err_ready,
    input  logic [E_PREC-1:0]     err,
    input  logic [N*X_PREC-1:0]   x_vec,
    output logic                  busy,
    output logic                  done,
    output logic                  sat,
    output logic [N*W_PREC-1:0]   w_vec
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int P_W   = E_PREC + X_PREC;
    // One bit wider than the wider addend so the sum can never wrap.
    localparam int S_W   = ((P_W > W_PREC) ? P_W : W_PREC) + 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [E_PREC-1:0]          r_err;
    logic [N*X_PREC-1:0]        r_x;
    logic [W_PREC-1:0]          r_w [N];
    logic                       r_sat;

    logic [X_PREC-1:0]          w_x;
    logic [W_PREC-1:0]          w_cur;
    logic [P_W-1:0]             w_err_ext;
    logic [P_W-1:0]             w_x_ext;
    logic signed [P_W-1:0]      w_prod;
    logic signed [P_W-1:0]      w_delta;
    logic signed [S_W-1:0]      w_sum;
    logic                       w_ovf;
    logic [W_PREC-1:0]          w_next;

    // Select the input element and weight addressed by the serial index.
    always_comb begin
        w_x   = '0;
        w_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_x   = r_x[i*X_PREC +: X_PREC];
                w_cur = r_w[i];
            end
        end
    end

    // Full-width signed product; operands sign-extended so it is exact.
    assign w_err_ext = {{X_PREC{r_err[E_PREC-1]}}, r_err};
    assign w_x_ext   = {{E_PREC{w_x[X_PREC-1]}}, w_x};
    assign w_prod    = $signed(w_err_ext) * $signed(w_x_ext);

    // Arithmetic shift floors toward minus infinity (-1 >>> 2 = -1).
    assign w_delta   = w_prod >>> LR_SHIFT;

    assign w_sum = $signed({{(S_W-W_PREC){w_cur[W_PREC-1]}}, w_cur})
                 + $signed({{(S_W-P_W){w_delta[P_W-1]}}, w_delta});

    // The sum fits in W_PREC bits only if all bits from the weight sign bit
    // upward agree; otherwise clamp toward the sign of the sum.
    assign w_ovf  = ~((&w_sum[S_W-1:W_PREC-1]) | ~(|w_sum[S_W-1:W_PREC-1]));
    assign w_next = w_ovf ? (w_sum[S_W-1] ? {1'b1, {(W_PREC-1){1'b0}}}
                                          : {1'b0, {(W_PREC-1){1'b1}}})
                          : w_sum[W_PREC-1:0];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_err   <= '0;
            r_x     <= '0;
            r_sat   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Weight initialisation wins over a pending error.
                    if (init_valid) begin
                        for (int i = 0; i < N; i++) begin
                            r_w[i] <= init_w[i*W_PREC +: W_PREC];
                        end
                    end else if (err_valid) begin
                        r_err   <= err;
                        r_x     <= x_vec;
                        r_idx   <= '0;
                        r_sat   <= 1'b0;
                        r_state <= (err == '0) ? S_DONE : S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_w[i] <= w_next;
                        end
                    end
                    if (w_ovf) begin
                        r_sat <= 1'b1;
                    end
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign err_ready = (r_state == S_IDLE) & ~init_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign sat       = r_sat;

    generate
        for (genvar g = 0; g < N; g++) begin : g_wvec
            assign w_vec[g*W_PREC +: W_PREC] = r_w[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_p_wt_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p_wt_update
//  Description : Self-checking bench for p_wt_update (N=4, W_PREC=8,
//                X_PREC=8, E_PREC=9, LR_SHIFT=2). Vector table applied
//                through a scoreboard queue, plus reset, backpressure and
//                init-priority sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_p_wt_update;

    logic        clk = 1'b0;
    logic        reset_;
    logic        init_valid;
    logic [31:0] init_w;
    logic        err_valid;
    logic        err_ready;
    logic [8:0]  err;
    logic [31:0] x_vec;
    logic        busy;
    logic        done;
    logic        sat;
    logic [31:0] w_vec;

    always #5 clk = ~clk;

    p_wt_update #(
        .N        (4),
        .W_PREC   (8),
        .X_PREC   (8),
        .E_PREC   (9),
        .LR_SHIFT (2)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .init_valid (init_valid),
        .init_w     (init_w),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .err        (err),
        .x_vec      (x_vec),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .w_vec      (w_vec)
    );

    typedef struct {
        string       name;
        logic [31:0] init;
        logic [8:0]  err;
        logic [31:0] x;
        logic [31:0] exp_w;
        logic        exp_sat;
        int          exp_lat;
    } vec_t;

    vec_t vt [7];
    vec_t sb [$];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] iw, input logic [8:0] e,
                                input logic [31:0] xv, input logic [31:0] ew,
                                input logic es, input int el);
        vec_t v;
        v.name = nm; v.init = iw; v.err = e; v.x = xv;
        v.exp_w = ew; v.exp_sat = es; v.exp_lat = el;
        return v;
    endfunction

    task automatic load(input logic [31:0] w);
        @(negedge clk);
        init_valid = 1'b1;
        init_w     = w;
        @(negedge clk);
        init_valid = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges including the handshake edge.
    task automatic wait_done(inout int lat);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   lat;
        load(v.init);
        sb.push_back(v);
        @(negedge clk);
        err       = v.err;
        x_vec     = v.x;
        err_valid = 1'b1;
        @(posedge clk); #1;
        err_valid = 1'b0;
        lat = 1;
        wait_done(lat);
        e = sb.pop_front();
        chk({e.name, " latency"}, lat, e.exp_lat);
        chk({e.name, " w_vec"}, w_vec, e.exp_w);
        chk({e.name, " sat"}, {31'd0, sat}, {31'd0, e.exp_sat});
        @(posedge clk); #1;
        chk({e.name, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;

        vt[0] = mk("basic",  p4(10,20,30,40),   9'd4,   p4(1,2,3,4),
                   p4(11,22,33,44),    1'b0, 5);
        vt[1] = mk("satpos", p4(120,0,0,0),     9'd255, p4(127,0,0,0),
                   p4(127,0,0,0),      1'b1, 5);
        vt[2] = mk("satneg", p4(0,-120,0,0),    9'h100, p4(0,127,0,0),
                   p4(0,-128,0,0),     1'b1, 5);
        vt[3] = mk("round",  p4(0,0,0,0),       9'h1FF, p4(1,1,1,1),
                   p4(-1,-1,-1,-1),    1'b0, 5);
        vt[4] = mk("mixsat", p4(100,-100,0,50), 9'd100, p4(10,-10,-127,1),
                   p4(127,-128,-128,75), 1'b1, 5);
        vt[5] = mk("zero",   p4(5,-6,7,-8),     9'd0,   p4(100,100,100,100),
                   p4(5,-6,7,-8),      1'b0, 1);
        vt[6] = mk("floor",  p4(0,0,0,0),       9'd3,   p4(1,-1,2,-2),
                   p4(0,-1,1,-2),      1'b0, 5);

        reset_ = 1'b0; init_valid = 1'b0; init_w = '0;
        err_valid = 1'b0; err = '0; x_vec = '0;
        #12;
        chk("reset w_vec", w_vec, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset sat", {31'd0, sat}, 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        #1;
        chk("reset err_ready", {31'd0, err_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i]);
        end

        // Reset in the middle of an update.
        load(p4(10,20,30,40));
        @(negedge clk);
        err = 9'd4; x_vec = p4(1,2,3,4); err_valid = 1'b1;
        @(posedge clk); #1;
        err_valid = 1'b0;
        @(posedge clk); #1;
        chk("midreset busy before", {31'd0, busy}, 32'd1);
        #2 reset_ = 1'b0;
        #1;
        chk("midreset w_vec", w_vec, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        #1;
        chk("midreset err_ready", {31'd0, err_ready}, 32'd1);

        // err_valid held through the update: consumed again only once IDLE.
        load(p4(0,0,0,0));
        @(negedge clk);
        err = 9'd4; x_vec = p4(1,2,3,4); err_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        chk("bp err_ready in update", {31'd0, err_ready}, 32'd0);
        wait_done(lat);
        chk("bp first latency", lat, 5);
        chk("bp first w_vec", w_vec, p4(1,2,3,4));
        chk("bp err_ready in done", {31'd0, err_ready}, 32'd0);
        @(posedge clk); #1;
        chk("bp idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("bp second accept", {31'd0, busy}, 32'd1);
        err_valid = 1'b0;
        lat = 1;
        wait_done(lat);
        chk("bp second w_vec", w_vec, p4(2,4,6,8));
        @(posedge clk); #1;

        // init_valid and err_valid together in IDLE: load wins, no handshake.
        @(negedge clk);
        init_valid = 1'b1; init_w = p4(1,1,1,1);
        err_valid = 1'b1; err = 9'd4; x_vec = p4(1,1,1,1);
        #1;
        chk("prio err_ready", {31'd0, err_ready}, 32'd0);
        @(posedge clk); #1;
        chk("prio busy", {31'd0, busy}, 32'd0);
        chk("prio w_vec", w_vec, p4(1,1,1,1));
        @(negedge clk);
        init_valid = 1'b0; err_valid = 1'b0;
        @(posedge clk); #1;
        chk("prio no update", w_vec, p4(1,1,1,1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
